mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_pkg.sv | 31 +++
 rtl/mmio_uart_tx_baud_counter.sv | 29 ++
 rtl/mmio_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared types and field positions for the memory-mapped UART
// transmitter. The config word comes from data-memory word 10; the status word
// is read back through word 11.
package mmio_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  // config word fields
  localparam int CFG_DATA_LSB   = 0;
  localparam int CFG_TOGGLE_BIT = 8;
  localparam int CFG_PARITY_BIT = 9;
  localparam int CFG_DIV_LSB    = 16;

  // status word fields
  localparam int STS_BUSY_BIT  = 0;
  localparam int STS_TX_BIT    = 1;
  localparam int STS_LAST_LSB  = 2;
  localparam int STS_COUNT_LSB = 16;

  // A zero divisor would make a bit zero clocks long; treat it as one clock.
  function automatic logic [15:0] eff_div(input logic [15:0] div_field);
    return (div_field == 16'd0) ? 16'd1 : div_field;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_baud_counter.sv
// uart_baud_counter: reloadable down-counter that times one UART bit.
// Loading div-1 and counting to zero gives a bit period of div clocks;
// tick is high while the count sits at zero.
module uart_baud_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  // reload on request, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter, LSB first.
// A request is raised by flipping config[8]; data and divisor are latched at
// acceptance so later config writes never disturb a frame in flight.
// Optional build macro MMIO_UART_TX_PARITY_EN adds a parity bit between the
// data bits and the stop bit (config[9]: 0 even, 1 odd).
//
// state  | meaning
// IDLE   | line high, waiting for a toggle mismatch
// START  | start bit (0) for div clocks
// DATA   | data bit bit_idx for div clocks, bit_idx 0..7
// PARITY | parity bit for div clocks (parity build only)
// STOP   | stop bit (1) for div clocks, frame counted on exit
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] config_register,
  output logic [31:0] status_register,
  output logic        tx
);

  state_t                 state;
  logic                   busy;
  logic                   seen_toggle;
  logic [7:0]             last_byte;
  logic [7:0]             data_r;
  logic [DIV_WIDTH-1:0]   div_r;
  logic [2:0]             bit_idx;
  logic [COUNT_WIDTH-1:0] frame_count;
`ifdef MMIO_UART_TX_PARITY_EN
  logic                   parity_r;
`endif

  logic                 pending;
  logic                 tick;
  logic                 load;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [DIV_WIDTH-1:0] load_value;

  assign cfg_div = eff_div(config_register[CFG_DIV_LSB +: 16]);
  assign pending = (state == IDLE) &&
                   (config_register[CFG_TOGGLE_BIT] != seen_toggle);

  // Every state change reloads the bit timer; on acceptance the divisor comes
  // straight from config because div_r is only written on that same edge.
  assign load       = pending || ((state != IDLE) && tick);
  assign load_value = pending ? (cfg_div - 1'b1) : (div_r - 1'b1);

  uart_baud_counter #(
    .WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_value(load_value),
    .tick      (tick)
  );

  // frame sequencer with registered line and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx          <= 1'b1;
      busy        <= 1'b0;
      seen_toggle <= 1'b0;
      last_byte   <= 8'h00;
      data_r      <= 8'h00;
      div_r       <= DIV_WIDTH'(1);
      bit_idx     <= 3'd0;
      frame_count <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            state       <= START;
            tx          <= 1'b0;
            busy        <= 1'b1;
            seen_toggle <= config_register[CFG_TOGGLE_BIT];
            last_byte   <= config_register[CFG_DATA_LSB +: 8];
            data_r      <= config_register[CFG_DATA_LSB +: 8];
            div_r       <= cfg_div;
            bit_idx     <= 3'd0;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_r    <= config_register[CFG_PARITY_BIT];
`endif
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            tx      <= data_r[0];
            bit_idx <= 3'd0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= (^data_r) ^ parity_r;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data_r[bit_idx + 3'd1];
            end
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_count <= frame_count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // status is assembled purely from registers
  always_comb begin
    status_register                       = 32'h0;
    status_register[STS_BUSY_BIT]         = busy;
    status_register[STS_TX_BIT]           = tx;
    status_register[STS_LAST_LSB +: 8]    = last_byte;
    status_register[STS_COUNT_LSB +: 16]  = 16'(frame_count);
  end

  // reserved config bits have no function in this block
`ifdef MMIO_UART_TX_PARITY_EN
  logic unused_cfg;
  assign unused_cfg = ^config_register[15:10];
`else
  logic unused_cfg;
  assign unused_cfg = ^config_register[15:9];
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed cases plus randomized frames
// compared against a per-clock line-level model built from the framing rules.
module tb_mmio_uart_tx;

  logic        clk;
  logic        reset;
  logic [31:0] config_register;
  logic [31:0] status_register;
  logic        tx;

  int          n_checks;
  int          n_errors;
  logic [31:0] cfg;
  logic [15:0] exp_count;
  logic [7:0]  exp_last;

  mmio_uart_tx dut (
    .clk            (clk),
    .reset          (reset),
    .config_register(config_register),
    .status_register(status_register),
    .tx             (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] idle_status();
    return {exp_count, 6'b0, exp_last, 1'b1, 1'b0};
  endfunction

  task automatic start_req(input logic [7:0] d, input logic [15:0] divf, input logic par);
    cfg = {divf, 6'b0, par, ~cfg[8], d};
    config_register = cfg;
  endtask

  task automatic idle_checks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_tx", {31'b0, tx}, 32'd1);
      check("idle_status", status_register, idle_status());
    end
  endtask

  // Expects a pending request at entry; the next edge accepts it.
  // n_mid toggles (with fresh data/div) are written during the frame.
  task automatic run_frame(input int n_mid);
    logic [7:0] d;
    int         eff;
    logic       par;
    logic       q[$];
    d   = cfg[7:0];
    eff = (cfg[31:16] == 16'd0) ? 1 : int'(cfg[31:16]);
    par = cfg[9];
    q.delete();
    for (int k = 0; k < eff; k++) q.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < eff; k++) q.push_back(d[b]);
`ifdef MMIO_UART_TX_PARITY_EN
    for (int k = 0; k < eff; k++) q.push_back((^d) ^ par);
`endif
    for (int k = 0; k < eff; k++) q.push_back(1'b1);
    exp_last = d;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      check("frame_tx", {31'b0, tx}, {31'b0, q[i]});
      check("frame_busy", {31'b0, status_register[0]}, 32'd1);
      check("frame_last", {24'b0, status_register[9:2]}, {24'b0, exp_last});
      if (i >= 1 && i <= n_mid) begin
        cfg[8]     = ~cfg[8];
        cfg[7:0]   = 8'($urandom);
        cfg[31:16] = 16'($urandom_range(0, 3));
        cfg[9]     = 1'($urandom);
        config_register = cfg;
      end
    end
    @(posedge clk); #1;
    exp_count++;
    check("frame_end_status", status_register, idle_status());
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_count = 16'd0;
    exp_last  = 8'd0;
    cfg       = 32'h0004_0055;
    config_register = cfg;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", status_register, 32'h0000_0002);
    check("reset_tx", {31'b0, tx}, 32'd1);
    reset = 1'b0;

    // no toggle: line stays idle
    idle_checks(20);

    // 0x55 at div 4
    start_req(8'h55, 16'd4, 1'b0);
    check("cfg_word", config_register, 32'h0004_0155);
    run_frame(0);
    check("count_after_55", {16'b0, status_register[31:16]}, 32'd1);
    check("last_after_55", {24'b0, status_register[9:2]}, 32'h55);

    // div field zero behaves as one clock per bit
    start_req(8'hA3, 16'd0, 1'b0);
    run_frame(0);

    // even toggles while busy: no second frame
    start_req(8'h5A, 16'd2, 1'b0);
    run_frame(2);
    idle_checks(6);

    // odd toggles while busy: one more frame after a single idle cycle
    start_req(8'h3C, 16'd1, 1'b0);
    run_frame(3);
    run_frame(0);
    idle_checks(3);

    // randomized frames
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(0, 3));
      start_req(8'($urandom), 16'($urandom_range(0, 5)), 1'($urandom));
      run_frame(n);
      if (n % 2 == 1) run_frame(0);
      idle_checks(2);
    end

`ifdef MMIO_UART_TX_PARITY_EN
    start_req(8'h07, 16'd2, 1'b0);
    run_frame(0);
    start_req(8'h07, 16'd2, 1'b1);
    run_frame(0);
`endif

    // reset at clock 15 of a div-4 frame
    start_req(8'hC3, 16'd4, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check("pre_abort_busy", {31'b0, status_register[0]}, 32'd1);
    end
    reset = 1'b1;
    cfg[8] = 1'b0;
    config_register = cfg;
    @(posedge clk); #1;
    exp_count = 16'd0;
    exp_last  = 8'd0;
    check("abort_tx", {31'b0, tx}, 32'd1);
    check("abort_status", status_register, 32'h0000_0002);
    reset = 1'b0;
    idle_checks(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
